exec_wb_stage: RTL and testbench
================================

// Module: exec_wb_stage
// PURPOSE
// Execute/write-back stage of the tiny RV core. Takes decoded ops with operands read from the
// 8-entry register file, computes the ALU result and drives the register file write port
// (we/wa/wd). Shifts are iterative to save area. A one-entry bypass covers read-after-write
// in the write-back cycle, because the register file only updates at the end of that cycle.
// PARAMETERS
// XLEN        32  datapath width
// SHIFT_STEP  1   bit positions shifted per cycle in SHIFT state; power of 2, 1..16
// PORTS
// clk          in   1     clock, all state on rising edge
// rst          in   1     synchronous reset, active-high
// in_valid     in   1     upstream op valid
// in_ready     out  1     stage can accept an op this cycle
// op           in   4     0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA,10 PASSB, 11-15 illegal
// rs1_idx      in   3     source-1 register index, used for bypass compare
// rs2_idx      in   3     source-2 register index, used for bypass compare
// rs1_val      in   XLEN  register file rd1
// rs2_val      in   XLEN  register file rd2
// imm          in   XLEN  immediate, already sign-extended
// use_imm      in   1     1: B operand = imm, 0: B = rs2 (after bypass)
// rd           in   3     destination index
// rf_we        out  1     register file write enable
// rf_wa        out  3     register file write address
// rf_wd        out  XLEN  register file write data
// busy         out  1     high in SHIFT state
// err          out  1     one-cycle pulse in WB state for an illegal op
// BEHAVIOUR
// - FSM: IDLE, SHIFT, WB. Accept = in_valid & in_ready. in_ready = !rst & (state==IDLE | state==WB).
// - Accepted op in cycle N: capture op, rd and operands.
//   - Shift op with shamt=B[4:0]!=0: go to SHIFT.
//   - All other ops (including shamt==0): compute in cycle N, register the result, go to WB in N+1.
// - SHIFT: each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining.
//   - When remaining reaches 0, go to WB. SHIFT lasts ceil(shamt/SHIFT_STEP) cycles; in_ready=0.
//   - SRA fills with the captured sign bit. SLL/SRL fill with zeros.
// - WB lasts one cycle. rf_we=1 iff rd!=0 and op legal. rf_wa=rd, rf_wd=result.
//   - Illegal op: rf_we=0, err=1. Next state: SHIFT/WB if an op is accepted this cycle, else IDLE.
// - Latency: non-shift op accepted at N writes at N+1. Shift writes at N+1+ceil(shamt/SHIFT_STEP).
// - Throughput: back-to-back accepts allowed (accept in WB), so one simple op per cycle.
// - Bypass: if state==WB, wb rd!=0, wb op legal and rs1_idx==wb rd, use the WB result instead
//   of rs1_val; same rule for rs2. Index 0 is never bypassed.
// - Arithmetic: ADD/SUB wrap mod 2^XLEN. SLT is signed, SLTU unsigned; result is 0 or 1
//   zero-extended. PASSB = B operand (LUI path).
// - rf_we, err and busy are combinational decodes of registered state only (no input-to-output
//   path). rf_wa/rf_wd are registered.
// - Reset: state=IDLE, rf_we=0, rf_wa=0, rf_wd=0, busy=0, err=0, in_ready=0 while rst=1.
//   An in-flight op (SHIFT or WB) is dropped with no write. Accept is possible in the first
//   cycle after rst falls.
// - in_valid=0 in IDLE: outputs hold at 0 enables; rf_wa/rf_wd are don't-care.
// TESTING
// 1 ADD rs1_val=5 rs2_val=7 rd=3 accepted at N -> at N+1: rf_we=1, rf_wa=3, rf_wd=12, in_ready=1.
// 2 SRA rs1=0x80000000, imm=4, use_imm=1, SHIFT_STEP=1 at N -> busy=1, in_ready=0 for N+1..N+4;
//   N+5: rf_wd=0xF8000000, rf_we=1.
// 3 ADD writes r2=9 (WB at N+1). ADDI rs1_idx=2 imm=1 accepted at N+1 with stale rs1_val=0
//   -> N+2: rf_wd=10.
// 4 ADD rd=0 -> no rf_we pulse. op=15 rd=4 -> err=1 for one cycle, rf_we=0.
// 5 SLL by 13 with SHIFT_STEP=4: rst=1 in the 2nd SHIFT cycle -> next cycle IDLE, busy=0,
//   no rf_we; after release in_ready=1. Re-run with no reset -> 4 SHIFT cycles, correct result.
// 6 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; SUB 0-1 -> 0xFFFFFFFF; SLL by 0 -> WB at N+1.

Source files
------------

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage of the tiny RV core.
// Takes a decoded op and its register-file operands. Computes the ALU result and drives the
// register-file write port. Shifts run iteratively, SHIFT_STEP bit positions per cycle.
// A one-entry bypass forwards the write-back result to an op accepted in the write-back cycle.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   op, rs1_idx, rs2_idx,       decoded op, source indices (for bypass), operand values,
//   rs1_val, rs2_val, imm,      sign-extended immediate, B-operand select,
//   use_imm, rd                 and destination index
//   rf_we, rf_wa, rf_wd         register-file write port
//   busy                        iterative shift in progress
//   err                         one-cycle pulse when an illegal op retires
module exec_wb_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [2:0]      rs1_idx,
  input  logic [2:0]      rs2_idx,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [2:0]      rd,
  output logic            rf_we,
  output logic [2:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            busy,
  output logic            err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StWb    = 2'd2;

  localparam logic [4:0] StepAmt = 5'(SHIFT_STEP);

  logic [1:0]      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;   // WB result; also the shift accumulator in StShift
  logic [4:0]      cnt_q, cnt_d;   // remaining shift amount

  logic            legal_q, byp_ok, accept, is_shift;
  logic [XLEN-1:0] opa, rs2_fwd, opb, alu_res, shift_res;
  logic [4:0]      shamt, step;

  assign legal_q  = (op_q <= 4'd10);
  assign in_ready = !rst && (state_q == StIdle || state_q == StWb);
  assign accept   = in_valid && in_ready;

  // The register file only commits at the end of the WB cycle, so its read data is stale.
  assign byp_ok  = (state_q == StWb) && (rd_q != 3'd0) && legal_q;
  assign opa     = (byp_ok && rs1_idx == rd_q) ? res_q : rs1_val;
  assign rs2_fwd = (byp_ok && rs2_idx == rd_q) ? res_q : rs2_val;
  assign opb     = use_imm ? imm : rs2_fwd;

  assign shamt    = opb[4:0];
  assign is_shift = (op == 4'd7) || (op == 4'd8) || (op == 4'd9);

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:    alu_res = opa + opb;
      4'd1:    alu_res = opa - opb;
      4'd2:    alu_res = opa & opb;
      4'd3:    alu_res = opa | opb;
      4'd4:    alu_res = opa ^ opb;
      4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      4'd6:    alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
      // Only a zero shift amount reaches here; non-zero shifts iterate in StShift.
      4'd7, 4'd8, 4'd9: alu_res = opa;
      4'd10:   alu_res = opb;
      default: alu_res = '0;
    endcase
  end

  assign step = (cnt_q < StepAmt) ? cnt_q : StepAmt;

  always_comb begin
    shift_res = res_q;
    case (op_q)
      4'd7:    shift_res = res_q << step;
      4'd8:    shift_res = res_q >> step;
      // The top bit never changes under >>>, so it keeps the captured sign.
      default: shift_res = $signed(res_q) >>> step;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      StShift: begin
        res_d = shift_res;
        cnt_d = cnt_q - step;
        if (cnt_q == step) state_d = StWb;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      op_d  = op;
      rd_d  = rd;
      cnt_d = shamt;
      if (is_shift && shamt != 5'd0) begin
        state_d = StShift;
        res_d   = opa;
      end else begin
        state_d = StWb;
        res_d   = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'd0;
      rd_q    <= 3'd0;
      res_q   <= '0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we = (state_q == StWb) && legal_q && (rd_q != 3'd0);
  assign err   = (state_q == StWb) && !legal_q;
  assign busy  = (state_q == StShift);
  assign rf_wa = rd_q;
  assign rf_wd = res_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: two instances (SHIFT_STEP 1 and 4) share one stimulus stream.
module tb_exec_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [2:0]  rs1_idx = 3'd0, rs2_idx = 3'd0, rd = 3'd0;
  logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0;
  logic        use_imm = 1'b0;

  logic        ready1, we1, busy1, err1;
  logic [2:0]  wa1;
  logic [31:0] wd1;
  logic        ready4, we4, busy4, err4;
  logic [2:0]  wa4;
  logic [31:0] wd4;

  int n_vec = 0;
  int n_err = 0;

  exec_wb_stage #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready1), .op(op),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .use_imm(use_imm), .rd(rd), .rf_we(we1), .rf_wa(wa1), .rf_wd(wd1),
    .busy(busy1), .err(err1)
  );

  exec_wb_stage #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready4), .op(op),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .use_imm(use_imm), .rd(rd), .rf_we(we4), .rf_wa(wa4), .rf_wd(wd4),
    .busy(busy4), .err(err4)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [2:0] i1, input logic [31:0] v1,
                       input logic [2:0] i2, input logic [31:0] v2, input logic [31:0] im,
                       input logic ui, input logic [2:0] d);
    op = o; rs1_idx = i1; rs1_val = v1; rs2_idx = i2; rs2_val = v2;
    imm = im; use_imm = ui; rd = d; in_valid = 1'b1;
  endtask

  // Architectural result of one op, straight from the ISA definition.
  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $signed(a) >>> b[4:0];
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(4'd0, 3'd1, 32'd1, 3'd2, 32'd2, 32'd0, 1'b0, 3'd3);
    tick(); tick();
    n_vec++;
    if ({ready1, ready4} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {ready1, ready4});
    end
    n_vec++;
    if ({we1, err1, busy1, wa1, wd1} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_outs: got we=%b err=%b busy=%b wa=%0d wd=%h want all 0",
               we1, err1, busy1, wa1, wd1);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_vec++;
    if (ready1 !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", ready1);
    end
    tick();
  endtask

  task automatic test_add();
    in_valid = 1'b0; tick();
    drive(4'd0, 3'd1, 32'd5, 3'd2, 32'd7, 32'd0, 1'b0, 3'd3);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({we1, wa1, wd1, ready1} !== {1'b1, 3'd3, 32'd12, 1'b1}) begin
      n_err++;
      $display("FAIL add: got we=%b wa=%0d wd=%h rdy=%b want 1 3 0000000c 1",
               we1, wa1, wd1, ready1);
    end
    tick();
  endtask

  task automatic test_sra();
    in_valid = 1'b0; tick();
    drive(4'd9, 3'd1, 32'h8000_0000, 3'd2, 32'd0, 32'd4, 1'b1, 3'd5);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_vec++;
      if ({busy1, ready1, we1} !== 3'b100) begin
        n_err++;
        $display("FAIL sra_busy cyc %0d: got busy=%b rdy=%b we=%b want 1 0 0",
                 i, busy1, ready1, we1);
      end
      if (i == 2) begin
        n_vec++;
        if ({we4, wd4} !== {1'b1, 32'hF800_0000}) begin
          n_err++; $display("FAIL sra_step4: got we=%b wd=%h want 1 f8000000", we4, wd4);
        end
      end
      tick();
    end
    n_vec++;
    if ({we1, wa1, wd1, busy1} !== {1'b1, 3'd5, 32'hF800_0000, 1'b0}) begin
      n_err++;
      $display("FAIL sra_wb: got we=%b wa=%0d wd=%h busy=%b want 1 5 f8000000 0",
               we1, wa1, wd1, busy1);
    end
    tick();
  endtask

  task automatic test_bypass();
    in_valid = 1'b0; tick();
    drive(4'd0, 3'd1, 32'd4, 3'd3, 32'd5, 32'd0, 1'b0, 3'd2);
    tick();
    n_vec++;
    if ({we1, wa1, wd1} !== {1'b1, 3'd2, 32'd9}) begin
      n_err++; $display("FAIL byp_producer: got we=%b wa=%0d wd=%h want 1 2 9", we1, wa1, wd1);
    end
    // ADDI from r2 with the stale register-file value.
    drive(4'd0, 3'd2, 32'd0, 3'd3, 32'd0, 32'd1, 1'b1, 3'd6);
    tick();
    n_vec++;
    if ({we1, wa1, wd1} !== {1'b1, 3'd6, 32'd10}) begin
      n_err++; $display("FAIL byp_rs1: got we=%b wa=%0d wd=%h want 1 6 10", we1, wa1, wd1);
    end
    drive(4'd0, 3'd1, 32'd3, 3'd6, 32'd0, 32'd0, 1'b0, 3'd7);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({we1, wa1, wd1} !== {1'b1, 3'd7, 32'd13}) begin
      n_err++; $display("FAIL byp_rs2: got we=%b wa=%0d wd=%h want 1 7 13", we1, wa1, wd1);
    end
    tick();
  endtask

  task automatic test_rd0_illegal();
    in_valid = 1'b0; tick();
    drive(4'd0, 3'd1, 32'd4, 3'd2, 32'd5, 32'd0, 1'b0, 3'd0);
    tick();
    n_vec++;
    if ({we1, err1} !== 2'b00) begin
      n_err++; $display("FAIL rd0_write: got we=%b err=%b want 0 0", we1, err1);
    end
    // r0 reads must never pick up the discarded rd=0 result.
    drive(4'd0, 3'd0, 32'd0, 3'd2, 32'd0, 32'd1, 1'b1, 3'd1);
    tick();
    n_vec++;
    if ({we1, wa1, wd1} !== {1'b1, 3'd1, 32'd1}) begin
      n_err++; $display("FAIL rd0_nobyp: got we=%b wa=%0d wd=%h want 1 1 1", we1, wa1, wd1);
    end
    drive(4'd15, 3'd1, 32'd1, 3'd2, 32'd2, 32'd0, 1'b0, 3'd4);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({we1, err1} !== 2'b01) begin
      n_err++; $display("FAIL illegal_wb: got we=%b err=%b want 0 1", we1, err1);
    end
    tick();
    n_vec++;
    if ({we1, err1} !== 2'b00) begin
      n_err++; $display("FAIL illegal_pulse: got we=%b err=%b want 0 0", we1, err1);
    end
  endtask

  task automatic test_compare();
    in_valid = 1'b0; tick();
    drive(4'd5, 3'd1, 32'hFFFF_FFFF, 3'd2, 32'd1, 32'd0, 1'b0, 3'd4);
    tick();
    n_vec++;
    if ({we1, wa1, wd1} !== {1'b1, 3'd4, 32'd1}) begin
      n_err++; $display("FAIL slt: got we=%b wa=%0d wd=%h want 1 4 1", we1, wa1, wd1);
    end
    drive(4'd6, 3'd1, 32'hFFFF_FFFF, 3'd2, 32'd1, 32'd0, 1'b0, 3'd5);
    tick();
    n_vec++;
    if ({we1, wa1, wd1} !== {1'b1, 3'd5, 32'd0}) begin
      n_err++; $display("FAIL sltu: got we=%b wa=%0d wd=%h want 1 5 0", we1, wa1, wd1);
    end
    drive(4'd1, 3'd1, 32'd0, 3'd2, 32'd1, 32'd0, 1'b0, 3'd6);
    tick();
    n_vec++;
    if ({we1, wa1, wd1} !== {1'b1, 3'd6, 32'hFFFF_FFFF}) begin
      n_err++; $display("FAIL sub: got we=%b wa=%0d wd=%h want 1 6 ffffffff", we1, wa1, wd1);
    end
    drive(4'd7, 3'd1, 32'h1234_5678, 3'd2, 32'd0, 32'd0, 1'b1, 3'd7);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({we1, busy1, wa1, wd1} !== {1'b1, 1'b0, 3'd7, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL sll0: got we=%b busy=%b wa=%0d wd=%h want 1 0 7 12345678",
               we1, busy1, wa1, wd1);
    end
    tick();
  endtask

  task automatic test_reset_shift();
    rst = 1'b1; in_valid = 1'b0; tick();
    rst = 1'b0;
    drive(4'd7, 3'd1, 32'd3, 3'd2, 32'd0, 32'd13, 1'b1, 3'd5);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (busy4 !== 1'b1) begin
      n_err++; $display("FAIL rstsh_busy1: got %b want 1", busy4);
    end
    tick();
    n_vec++;
    if (busy4 !== 1'b1) begin
      n_err++; $display("FAIL rstsh_busy2: got %b want 1", busy4);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({busy4, we4, ready4} !== 3'b001) begin
      n_err++;
      $display("FAIL rstsh_drop: got busy=%b we=%b rdy=%b want 0 0 1", busy4, we4, ready4);
    end
    drive(4'd7, 3'd1, 32'd3, 3'd2, 32'd0, 32'd13, 1'b1, 3'd5);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({busy4, ready4, we4} !== 3'b100) begin
        n_err++;
        $display("FAIL rstsh_rerun cyc %0d: got busy=%b rdy=%b we=%b want 1 0 0",
                 i, busy4, ready4, we4);
      end
      tick();
    end
    n_vec++;
    if ({we4, busy4, wa4, wd4} !== {1'b1, 1'b0, 3'd5, 32'd3 << 13}) begin
      n_err++;
      $display("FAIL rstsh_result: got we=%b busy=%b wa=%0d wd=%h want 1 0 5 %h",
               we4, busy4, wa4, wd4, 32'd3 << 13);
    end
  endtask

  // Random op stream against an architectural register-file model. When an op is issued in
  // its producer's WB cycle, the forwarded register is driven with garbage, as the real
  // register file has not committed yet.
  task automatic test_random();
    logic [31:0] rf_m[8];
    logic        prev_valid, prev_we;
    logic [2:0]  prev_rd;
    rst = 1'b1; in_valid = 1'b0; tick();
    rst = 1'b0;
    rf_m[0] = '0;
    for (int i = 1; i < 8; i++) rf_m[i] = $urandom;
    prev_valid = 1'b0; prev_we = 1'b0; prev_rd = 3'd0;
    for (int k = 0; k < 200; k++) begin
      logic [3:0]  o;
      logic [2:0]  i1, i2, d;
      logic [31:0] a, b, im, v1, v2, exp;
      logic        ui, gap, legal, exp_we;
      int          nsh;
      o   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                        : 4'($urandom_range(0, 10));
      i1  = 3'($urandom_range(0, 7));
      i2  = 3'($urandom_range(0, 7));
      d   = 3'($urandom_range(0, 7));
      ui  = 1'($urandom_range(0, 1));
      im  = $urandom;
      gap = !prev_valid || ($urandom_range(0, 2) == 0);
      if (gap) begin
        in_valid = 1'b0;
        tick();
        n_vec++;
        if ({we1, err1, busy1} !== 3'b000) begin
          n_err++; $display("FAIL rnd_idle %0d: got we=%b err=%b busy=%b want 0 0 0",
                            k, we1, err1, busy1);
        end
      end
      a      = rf_m[i1];
      b      = ui ? im : rf_m[i2];
      exp    = ref_alu(o, a, b);
      legal  = (o <= 4'd10);
      exp_we = legal && (d != 3'd0);
      v1 = (!gap && prev_we && i1 == prev_rd) ? $urandom : rf_m[i1];
      v2 = (!gap && prev_we && i2 == prev_rd) ? $urandom : rf_m[i2];
      drive(o, i1, v1, i2, v2, im, ui, d);
      n_vec++;
      if (ready1 !== 1'b1) begin
        n_err++; $display("FAIL rnd_ready %0d: got %b want 1", k, ready1);
      end
      tick();
      in_valid = 1'b0;
      nsh = (o >= 4'd7 && o <= 4'd9) ? int'(b[4:0]) : 0;
      for (int s = 0; s < nsh; s++) begin
        n_vec++;
        if ({busy1, ready1, we1} !== 3'b100) begin
          n_err++; $display("FAIL rnd_shift %0d cyc %0d: got busy=%b rdy=%b we=%b want 1 0 0",
                            k, s, busy1, ready1, we1);
        end
        tick();
      end
      n_vec++;
      if ({we1, err1, busy1} !== {exp_we, !legal, 1'b0}) begin
        n_err++; $display("FAIL rnd_ctl %0d op=%0d: got we=%b err=%b busy=%b want %b %b 0",
                          k, o, we1, err1, busy1, exp_we, !legal);
      end
      if (exp_we) begin
        n_vec++;
        if ({wa1, wd1} !== {d, exp}) begin
          n_err++; $display("FAIL rnd_data %0d op=%0d: got wa=%0d wd=%h want %0d %h",
                            k, o, wa1, wd1, d, exp);
        end
        rf_m[d] = exp;
      end
      prev_valid = 1'b1;
      prev_we    = exp_we;
      prev_rd    = d;
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sra();
    test_bypass();
    test_rd0_illegal();
    test_compare();
    test_reset_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
